alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice per cycle, LSB first, with IDLE/RUN/FIN control.
// Optional macro ALU_SERIAL_OVF_EN enables the signed overflow flag and overflow-corrected SLT.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               msb_sum_q, msb_sum_d;
`ifdef ALU_SERIAL_OVF_EN
    logic               msb_ovf_q, msb_ovf_d;
    logic               arith_c;
`endif

    logic               sa_c, sb_c, and_c, or_c, sum_c, cout_c;
    logic               mux_c, bit_c, op_valid_c, last_c, slt_set_c, ovf_fin_c;
    logic [WIDTH-1:0]   res_fin_c;

    // Single 1-bit ALU slice operating on the current LSB of the operand shifters.
    always_comb begin
        sa_c   = a_q[0] ^ op_q[3];
        sb_c   = b_q[0] ^ op_q[2];
        and_c  = sa_c & sb_c;
        or_c   = sa_c | sb_c;
        sum_c  = sa_c ^ sb_c ^ carry_q;
        cout_c = (sa_c & sb_c) | (sa_c & carry_q) | (sb_c & carry_q);
        case (op_q[1:0])
            2'b00:   mux_c = and_c;
            2'b01:   mux_c = or_c;
            2'b10:   mux_c = sum_c;
            default: mux_c = 1'b0;
        endcase
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_valid_c = 1'b1;
            default:                                       op_valid_c = 1'b0;
        endcase
        bit_c  = op_valid_c ? mux_c : 1'b0;
        last_c = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Finishing values applied when leaving FIN.
    always_comb begin
`ifdef ALU_SERIAL_OVF_EN
        arith_c   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
        slt_set_c = msb_sum_q ^ msb_ovf_q;
        ovf_fin_c = arith_c ? msb_ovf_q : 1'b0;
`else
        slt_set_c = msb_sum_q;
        ovf_fin_c = 1'b0;
`endif
        res_fin_c = res_q;
        if (op_q == OP_SLT) begin
            res_fin_c[0] = slt_set_c;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        msb_sum_d = msb_sum_q;
`ifdef ALU_SERIAL_OVF_EN
        msb_ovf_d = msb_ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = ALUOp;
                    cnt_d   = '0;
                    carry_d = ALUOp[2];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = {bit_c, res_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cout_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    msb_sum_d = sum_c;
`ifdef ALU_SERIAL_OVF_EN
                    msb_ovf_d = carry_q ^ cout_c;
`endif
                    cnt_d     = '0;
                    state_d   = S_FIN;
                end
            end
            S_FIN: begin
                res_d   = res_fin_c;
                zero_d  = (res_fin_c == '0);
                ovf_d   = ovf_fin_c;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            msb_sum_q <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            msb_ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            msb_sum_q <= msb_sum_d;
`ifdef ALU_SERIAL_OVF_EN
            msb_ovf_q <= msb_ovf_d;
`endif
        end
    end

    assign Result   = res_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=24): vector table plus reset/ignore-Start sequences.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 24;
    localparam int LAT = W + 1;

`ifdef ALU_SERIAL_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [W-1:0] A, B;
    logic [3:0]   ALUOp;
    logic [W-1:0] Result;
    logic         Zero, Overflow, Busy, Done;

    int errors = 0;
    int checks = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .A(A), .B(B), .ALUOp(ALUOp),
        .Result(Result), .Zero(Zero), .Overflow(Overflow), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for Done; returns cycles from accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          output int lat);
        @(negedge CLK);
        A = a; B = b; ALUOp = op; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        A = ~a; B = ~b; ALUOp = ~op;
        chk("busy_after_start", 32'(Busy), 32'd1);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge CLK); #1;
            if (Done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got none expected Done within 60 cycles");
        end
    endtask

    initial begin
        int lat;
        int dcount;
        logic [W-1:0] held;

        vecs[0]  = '{"add_5_3",     24'h000005, 24'h000003, 4'b0010, 24'h000008, 1'b0, 1'b0};
        vecs[1]  = '{"sub_3_5",     24'h000003, 24'h000005, 4'b0110, 24'hFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{"sub_eq",      24'h123456, 24'h123456, 4'b0110, 24'h000000, 1'b1, 1'b0};
        vecs[3]  = '{"slt_m1_1",    24'hFFFFFF, 24'h000001, 4'b0111, 24'h000001, 1'b0, 1'b0};
        vecs[4]  = '{"slt_1_m1",    24'h000001, 24'hFFFFFF, 4'b0111, 24'h000000, 1'b1, 1'b0};
        vecs[5]  = '{"add_ovf",     24'h7FFFFF, 24'h000001, 4'b0010, 24'h800000, 1'b0, OVF_ON};
        vecs[6]  = '{"slt_ovf",     24'h7FFFFF, 24'h800000, 4'b0111,
                     OVF_ON ? 24'h000000 : 24'h000001, OVF_ON, OVF_ON};
        vecs[7]  = '{"and",         24'hF0F0F0, 24'h0FF00F, 4'b0000, 24'h00F000, 1'b0, 1'b0};
        vecs[8]  = '{"or",          24'hF0F0F0, 24'h0FF00F, 4'b0001, 24'hFFF0FF, 1'b0, 1'b0};
        vecs[9]  = '{"nor",         24'h0000F0, 24'h00000F, 4'b1100, 24'hFFFF00, 1'b0, 1'b0};
        vecs[10] = '{"bad_0011",    24'h000005, 24'h000003, 4'b0011, 24'h000000, 1'b1, 1'b0};
        vecs[11] = '{"add_wrap",    24'hFFFFFF, 24'h000001, 4'b0010, 24'h000000, 1'b1, 1'b0};
        vecs[12] = '{"bad_1010",    24'h7FFFFF, 24'h000001, 4'b1010, 24'h000000, 1'b1, 1'b0};

        RESET = 1'b1; Start = 1'b0; A = '0; B = '0; ALUOp = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_zero", 32'(Zero), 32'd1);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
            chk({vecs[i].name, "_res"}, 32'(Result), 32'(vecs[i].res));
            chk({vecs[i].name, "_zero"}, 32'(Zero), 32'(vecs[i].zero));
            chk({vecs[i].name, "_ovf"}, 32'(Overflow), 32'(vecs[i].ovf));
            chk({vecs[i].name, "_busy"}, 32'(Busy), 32'd0);
            held = Result;
            @(posedge CLK); #1;
            chk({vecs[i].name, "_done_pulse"}, 32'(Done), 32'd0);
            chk({vecs[i].name, "_hold"}, 32'(Result), 32'(held));
        end

        // Reset at RUN cycle 10 aborts the operation without a Done pulse.
        @(negedge CLK);
        A = 24'h000005; B = 24'h000003; ALUOp = 4'b0010; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_result", 32'(Result), 32'd0);
        chk("abort_zero", 32'(Zero), 32'd1);
        dcount = 0;
        for (int n = 0; n < 30; n++) begin
            if (Done) dcount++;
            @(posedge CLK); #1;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        run_op(24'h000005, 24'h000003, 4'b0010, lat);
        chk("after_abort_lat", 32'(lat), 32'(LAT));
        chk("after_abort_res", 32'(Result), 32'h8);

        // Reset wins over Start in the same cycle.
        @(negedge CLK);
        RESET = 1'b1; Start = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; Start = 1'b0;
        chk("rst_prio_busy", 32'(Busy), 32'd0);
        @(posedge CLK); #1;
        chk("rst_prio_busy2", 32'(Busy), 32'd0);

        // Start re-pulsed at RUN cycle 5 and in FIN with new operands is ignored.
        @(negedge CLK);
        A = 24'h000005; B = 24'h000003; ALUOp = 4'b0010; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        dcount = 0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK); #1;
            if (Done) begin
                dcount++;
                if (lat < 0) lat = n;
            end
            if (n == 5 || n == 24) begin
                chk($sformatf("ign_busy_%0d", n), 32'(Busy), 32'd1);
                A = 24'h00FFFF; B = 24'h000100; ALUOp = 4'b0110; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (n == LAT) begin
                chk("ign_res", 32'(Result), 32'h8);
            end
        end
        chk("ign_lat", 32'(lat), 32'(LAT));
        chk("ign_done_count", 32'(dcount), 32'd1);
        chk("ign_idle", 32'(Busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
